// File: rtl/sopc_timer.sv
// Memory-mapped timer: CTRL/COUNT/COMPARE/STATUS behind a zero-latency bus window,
// with a prescaled up counter, compare match and a sticky interrupt flag.
module sopc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        timer_int_o
);

  localparam logic [31:0] PRESC_MAX = 32'(PRESCALE - 32'd1);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return merged;
  endfunction

  logic [2:0]  ctrl_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        pend_r;
  logic [31:0] presc_r;

  logic        hit_s;
  logic        wr_s;
  logic        rd_s;
  logic        wr_ctrl_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_status_s;
  logic [2:0]  ctrl_wdata_s;
  logic        en_nxt_s;
  logic        presc_run_s;
  logic        tick_s;
  logic        match_s;
  logic        w1c_s;
  logic        addr_unused_s;

  assign hit_s         = ce & (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_s          = hit_s & we;
  assign rd_s          = hit_s & ~we;
  assign wr_ctrl_s     = wr_s & (addr[3:2] == 2'd0);
  assign wr_count_s    = wr_s & (addr[3:2] == 2'd1);
  assign wr_compare_s  = wr_s & (addr[3:2] == 2'd2);
  assign wr_status_s   = wr_s & (addr[3:2] == 2'd3);
  assign addr_unused_s = &{1'b0, addr[1:0]};

  // CTRL only has bits in lane 0, so only sel[0] can change it.
  assign ctrl_wdata_s = sel[0] ? data_i[2:0] : ctrl_r;
  assign en_nxt_s     = wr_ctrl_s ? ctrl_wdata_s[0] : ctrl_r[0];

  // A write that clears EN suppresses the tick in that same cycle.
  assign presc_run_s = ctrl_r[0] & en_nxt_s;
  assign tick_s      = presc_run_s & (presc_r == PRESC_MAX);
  assign match_s     = tick_s & (count_r == compare_r);
  assign w1c_s       = wr_status_s & sel[0] & data_i[0];

  assign timer_int_o = pend_r & ctrl_r[2];

  // Register state: reset, bus writes, prescaler, counter and sticky match flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_r    <= 3'd0;
      count_r   <= 32'd0;
      compare_r <= 32'hFFFF_FFFF;
      pend_r    <= 1'b0;
      presc_r   <= 32'd0;
    end else begin
      if (wr_ctrl_s) begin
        ctrl_r <= ctrl_wdata_s;
      end

      if (!presc_run_s || tick_s) begin
        presc_r <= 32'd0;
      end else begin
        presc_r <= presc_r + 32'd1;
      end

      // A bus write owns the counter for that cycle; unwritten lanes keep their value.
      if (wr_count_s) begin
        count_r <= merge_bytes(count_r, data_i, sel);
      end else if (match_s && ctrl_r[1]) begin
        count_r <= 32'd0;
      end else if (tick_s) begin
        count_r <= count_r + 32'd1;
      end

      if (wr_compare_s) begin
        compare_r <= merge_bytes(compare_r, data_i, sel);
      end

      if (match_s) begin
        pend_r <= 1'b1;
      end else if (w1c_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  // Zero-latency read mux; returns 0 whenever the access does not hit as a read.
  always_comb begin
    data_o = 32'd0;
    if (rd_s) begin
      case (addr[3:2])
        2'd0:    data_o = {29'd0, ctrl_r};
        2'd1:    data_o = count_r;
        2'd2:    data_o = compare_r;
        2'd3:    data_o = {31'd0, pend_r};
        default: data_o = 32'd0;
      endcase
    end else begin
      data_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_sopc_timer.sv
// Scoreboard bench for sopc_timer: one instance with PRESCALE=1, one with PRESCALE=4,
// each in its own address window on a shared bus.
module tb_sopc_timer;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o0;
  logic [31:0] data_o1;
  logic        int0;
  logic        int1;

  sopc_timer #(.BASE_ADDR(A0), .PRESCALE(1)) u_t0 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o0), .timer_int_o(int0)
  );

  sopc_timer #(.BASE_ADDR(A1), .PRESCALE(4)) u_t1 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o1), .timer_int_o(int1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          dut;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce     = 1'b0;
    we     = 1'b0;
    addr   = 32'd0;
    sel    = 4'd0;
    data_i = 32'd0;
  endtask

  task automatic bus_wr(input logic c, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
    ce     = c;
    we     = 1'b1;
    addr   = a;
    sel    = s;
    data_i = d;
    step();
    bus_idle();
  endtask

  task automatic bus_rd(input string tag, input logic c, input logic [31:0] a,
                        input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    e.dut = (a[31:28] == 4'h2);
    sb_q.push_back(e);
    ce   = c;
    we   = 1'b0;
    addr = a;
    #3;
    e = sb_q.pop_front();
    check_eq(e.tag, e.dut ? data_o1 : data_o0, e.exp);
    check_eq({e.tag, "_other"}, e.dut ? data_o0 : data_o1, 32'd0);
    step();
    bus_idle();
  endtask

  initial begin
    rst = 1'b0;
    bus_idle();
    step();
    step();
    rst = 1'b1;

    // Reset values and readback
    bus_rd("rst_ctrl", 1'b1, A0 + 32'h0, 32'd0);
    bus_rd("rst_count", 1'b1, A0 + 32'h4, 32'd0);
    bus_rd("rst_compare", 1'b1, A0 + 32'h8, 32'hFFFF_FFFF);
    bus_rd("rst_status", 1'b1, A0 + 32'hC, 32'd0);
    check_eq("rst_int0", {31'd0, int0}, 32'd0);
    check_eq("rst_int1", {31'd0, int1}, 32'd0);

    // Byte-lane write
    bus_wr(1'b1, A0 + 32'h8, 4'b0101, 32'hAABB_CCDD);
    bus_rd("lane_compare", 1'b1, A0 + 32'h8, 32'hFFBB_FFDD);

    // Address decode: out-of-window and ce=0 accesses do nothing
    bus_wr(1'b1, A0 + 32'h10, 4'hF, 32'h0000_0007);
    bus_wr(1'b0, A0 + 32'h8, 4'hF, 32'h1234_5678);
    bus_rd("dec_miss_rd", 1'b1, A0 + 32'h10, 32'd0);
    bus_rd("dec_ce0_rd", 1'b0, A0 + 32'h8, 32'd0);
    bus_rd("dec_ctrl", 1'b1, A0 + 32'h0, 32'd0);
    bus_rd("dec_compare", 1'b1, A0 + 32'h8, 32'hFFBB_FFDD);

    // Auto-reload interrupt with PRESCALE=1
    bus_wr(1'b1, A0 + 32'h8, 4'hF, 32'd3);
    bus_wr(1'b1, A0 + 32'h0, 4'hF, 32'd7);
    for (int i = 0; i < 4; i++) begin
      bus_rd("ar_count", 1'b1, A0 + 32'h4, 32'(i));
    end
    check_eq("ar_int_set", {31'd0, int0}, 32'd1);
    bus_rd("ar_status_set", 1'b1, A0 + 32'hC, 32'd1);
    bus_wr(1'b1, A0 + 32'hC, 4'b0001, 32'd1);
    check_eq("ar_int_clr", {31'd0, int0}, 32'd0);
    bus_rd("ar_status_clr", 1'b1, A0 + 32'hC, 32'd0);
    bus_rd("ar_status_wait", 1'b1, A0 + 32'hC, 32'd0);
    check_eq("ar_int_again", {31'd0, int0}, 32'd1);

    // W1C on the match cycle: set wins
    bus_wr(1'b1, A0 + 32'hC, 4'b0001, 32'd1);
    bus_rd("w1c_clr", 1'b1, A0 + 32'hC, 32'd0);
    bus_rd("w1c_count", 1'b1, A0 + 32'h4, 32'd2);
    bus_wr(1'b1, A0 + 32'hC, 4'b0001, 32'd1);
    bus_rd("w1c_setwins", 1'b1, A0 + 32'hC, 32'd1);

    // COUNT writes during ticks take the written bytes
    bus_wr(1'b1, A0 + 32'h4, 4'hF, 32'h0000_0100);
    bus_rd("cw_full", 1'b1, A0 + 32'h4, 32'h0000_0100);
    bus_wr(1'b1, A0 + 32'h4, 4'b0001, 32'h0000_00AA);
    bus_rd("cw_lane", 1'b1, A0 + 32'h4, 32'h0000_01AA);

    // Clearing EN takes no tick in that cycle
    bus_wr(1'b1, A0 + 32'h0, 4'hF, 32'd0);
    bus_rd("en_off_hold", 1'b1, A0 + 32'h4, 32'h0000_01AB);

    // Wrap with AUTORELOAD=0
    bus_wr(1'b1, A0 + 32'h8, 4'hF, 32'd5);
    bus_wr(1'b1, A0 + 32'h4, 4'hF, 32'hFFFF_FFFF);
    bus_wr(1'b1, A0 + 32'hC, 4'b0001, 32'd1);
    bus_wr(1'b1, A0 + 32'h0, 4'hF, 32'd1);
    bus_rd("wrap_max", 1'b1, A0 + 32'h4, 32'hFFFF_FFFF);
    bus_rd("wrap_zero", 1'b1, A0 + 32'h4, 32'd0);
    bus_rd("wrap_nopend", 1'b1, A0 + 32'hC, 32'd0);

    // Prescaler with PRESCALE=4
    bus_wr(1'b1, A1 + 32'h0, 4'hF, 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus_rd("psc_p0", 1'b1, A1 + 32'h4, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      bus_rd("psc_p1", 1'b1, A1 + 32'h4, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      bus_rd("psc_p2", 1'b1, A1 + 32'h4, 32'd2);
    end
    bus_wr(1'b1, A1 + 32'h0, 4'hF, 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus_rd("psc_hold", 1'b1, A1 + 32'h4, 32'd2);
    end
    bus_wr(1'b1, A1 + 32'h0, 4'hF, 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus_rd("psc_restart", 1'b1, A1 + 32'h4, 32'd2);
    end
    bus_rd("psc_next", 1'b1, A1 + 32'h4, 32'd3);

    // Reset mid-operation beats a simultaneous write
    bus_wr(1'b1, A0 + 32'h0, 4'hF, 32'd7);
    rst    = 1'b0;
    ce     = 1'b1;
    we     = 1'b1;
    addr   = A0 + 32'h4;
    sel    = 4'hF;
    data_i = 32'h0000_1234;
    step();
    rst = 1'b1;
    bus_idle();
    bus_rd("rst2_ctrl", 1'b1, A0 + 32'h0, 32'd0);
    bus_rd("rst2_count", 1'b1, A0 + 32'h4, 32'd0);
    bus_rd("rst2_compare", 1'b1, A0 + 32'h8, 32'hFFFF_FFFF);
    bus_rd("rst2_status", 1'b1, A0 + 32'hC, 32'd0);
    bus_rd("rst2_t1_count", 1'b1, A1 + 32'h4, 32'd0);
    check_eq("rst2_int0", {31'd0, int0}, 32'd0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
